// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder among NUM_REQ
// requesters; the result lands in a single-entry valid/ready output register.

module CarryLookAheadAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);
    logic [8:0] grp_c;

    assign grp_c[0] = Cin;

    // 4-bit lookahead groups; group generate/propagate form the block carry chain
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_grp
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g    = a[4*gi +: 4] & b[4*gi +: 4];
            assign p    = a[4*gi +: 4] ^ b[4*gi +: 4];
            assign c[0] = grp_c[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign S[4*gi +: 4] = p ^ c;
            assign grp_c[gi+1]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                                | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c[0]);
        end
    endgenerate

    assign Cout = grp_c[8];
endmodule

module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_cout
);
    logic [ID_W-1:0] last_grant_reg;
    logic            rsp_valid_reg;
    logic [31:0]     rsp_sum_reg;
    logic            rsp_cout_reg;
    logic [ID_W-1:0] rsp_id_reg;

    logic [ID_W-1:0] win;
    logic            any_valid;
    logic            can_accept;
    logic            grant_ok;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic            add_cin;
    logic [31:0]     add_s;
    logic            add_cout;
    int              idx;

    // Scan from farthest to nearest so the nearest valid requester after
    // last_grant is the final assignment and therefore wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant_reg) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                win       = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign can_accept = !rsp_valid_reg || rsp_ready;
    assign grant_ok   = rst_n && can_accept && any_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_ok && (win == ID_W'(gi));
        end
    endgenerate

    // Only the winner's lane reaches the adder, so junk on other lanes stays out.
    assign add_a   = req_a[int'(win)*32 +: 32];
    assign add_b   = req_b[int'(win)*32 +: 32];
    assign add_cin = req_cin[win];

    CarryLookAheadAdder u_cla (
        .a    (add_a),
        .b    (add_b),
        .Cin  (add_cin),
        .S    (add_s),
        .Cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            rsp_valid_reg  <= 1'b0;
            rsp_sum_reg    <= '0;
            rsp_cout_reg   <= 1'b0;
            rsp_id_reg     <= '0;
        end else if (grant_ok) begin
            last_grant_reg <= win;
            rsp_valid_reg  <= 1'b1;
            rsp_sum_reg    <= add_s;
            rsp_cout_reg   <= add_cout;
            rsp_id_reg     <= win;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign rsp_id    = rsp_id_reg;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: a requester/arbitration model predicts
// grants and results, and a negedge monitor compares every presented response.

module tb_adder_share_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]    req_cin = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_sum;
    logic            rsp_cout;

    int total = 0;
    int bad   = 0;

    // Expected response: {id[1:0], cout, sum[31:0]}
    logic [34:0] q[$];

    // Requester and arbiter model state
    logic [N-1:0] pend = '0;
    logic [31:0]  pa[N];
    logic [31:0]  pb[N];
    logic         pc[N];
    int           last_grant = N - 1;
    logic         exp_full = 1'b0;

    adder_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pc[i]   = c;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One cycle: drive at posedge+1, check combinational grant, update model.
    task automatic step(input logic rr);
        int          w;
        int          idx;
        logic [N-1:0] exp_rdy;
        logic [32:0] s;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = pend[i] ? pa[i] : $urandom;
            req_b[i*32 +: 32] = pend[i] ? pb[i] : $urandom;
            req_cin[i]        = pend[i] ? pc[i] : 1'($urandom_range(0, 1));
        end
        req_valid = pend;
        rsp_ready = rr;
        #1;
        w = -1;
        exp_rdy = '0;
        if (pend != '0 && (!exp_full || rr)) begin
            for (int k = 1; k <= N && w < 0; k++) begin
                idx = (last_grant + k) % N;
                if (pend[idx]) w = idx;
            end
            exp_rdy[w] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_full));
        if (w >= 0) begin
            s = {1'b0, pa[w]} + {1'b0, pb[w]} + {32'd0, pc[w]};
            q.push_back({2'(w), s});
            $display("accept req=%0d a=0x%08h b=0x%08h cin=%0d -> sum=0x%08h cout=%0d",
                     w, pa[w], pb[w], pc[w], s[31:0], s[32]);
            last_grant = w;
            exp_full   = 1'b1;
            pend[w]    = 1'b0;
        end else if (exp_full && rr) begin
            exp_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear immediately.
    task automatic do_reset();
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("rst_rsp_cout",  64'(rsp_cout),  64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        #1;
        rst_n      = 1'b1;
        req_valid  = '0;
        q.delete();
        pend       = '0;
        last_grant = N - 1;
        exp_full   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the held response every cycle, retire it on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got id=%0d sum=0x%08h with nothing expected",
                             rsp_id, rsp_sum);
                end else begin
                    chk("rsp_payload", 64'({rsp_id, rsp_cout, rsp_sum}), 64'(q[0]));
                    if (rsp_ready) begin
                        $display("response id=%0d sum=0x%08h cout=%0d", rsp_id, rsp_sum, rsp_cout);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();

        // Single request and carry/wrap corners
        load(2, 32'h0000_0005, 32'h0000_0003, 1'b1);
        step(1'b1);
        load(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        step(1'b1);
        load(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // Round-robin from reset with all requesters busy, then backpressure
        do_reset();
        for (int i = 0; i < N; i++) load(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            for (int i = 0; i < N; i++)
                if (!pend[i]) load(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        repeat (3) step(1'b0);
        for (int c = 0; c < 10 && (pend != '0 || exp_full); c++) step(1'b1);

        // Priority retention across idle cycles
        do_reset();
        load(1, 32'd10, 32'd20, 1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        load(0, 32'd100, 32'd1, 1'b0);
        load(3, 32'd300, 32'd3, 1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // Reset while stalled, then restart at requester 0
        load(2, 32'h1234_5678, 32'h1111_1111, 1'b0);
        step(1'b0);
        step(1'b0);
        do_reset();
        load(0, 32'd7, 32'd8, 1'b0);
        load(2, 32'd9, 32'd10, 1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // Randomized traffic with random backpressure
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    load(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
            step($urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 20 && (pend != '0 || exp_full); c++) step(1'b1);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
Name:
adder_share_arbiter

Overview:
- Shares one 32-bit carry-lookahead adder instance (CarryLookAheadAdder: a, b, Cin -> S, Cout) among NUM_REQ requesters.
- Round-robin arbitration; each requester uses a valid/ready request handshake.
- Sum, carry and requester ID land in a single-entry output register drained by a valid/ready response handshake.
- Sits between the ALU issue logic and the adder; throughput is one add per cycle when unstalled.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B, same packing.
- req_cin  in  NUM_REQ  carry-in per requester.
- rsp_valid  out  1  output register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_sum  out  32  registered S.
- rsp_cout  out  1  registered Cout.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority on the first arbitration.
  - req_ready=0 while rst_n=0.
- can_accept = !rsp_valid | rsp_ready (combinational). Draining and refilling in the same cycle is allowed.
- Arbitration (combinational):
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, ascending with wrap.
  - The first set bit is the winner w.
  - req_ready = onehot(w) when can_accept and any req_valid; otherwise 0.
  - req_ready never depends on the winner's own operand values.
- Datapath: the adder is fed mux(req_a, w), mux(req_b, w), req_cin[w].
- Accept occurs at the clock edge where req_valid[w] & req_ready[w]. On accept:
  - rsp_sum<=S, rsp_cout<=Cout, rsp_id<=w, rsp_valid<=1, last_grant<=w.
- If there is no accept but rsp_valid & rsp_ready, then rsp_valid<=0. Payload registers keep their old values.
- Latency: a request accepted at edge t gives rsp_valid=1 in the cycle after t.
- Stall: while rsp_valid=1 and rsp_ready=0, rsp_sum, rsp_cout and rsp_id hold stable and all req_ready=0.
- last_grant updates only on accept; idle cycles do not rotate priority.
- Fairness: a requester holding req_valid is granted within NUM_REQ accepts.
- Requester obligation: once req_valid is raised, hold it and the payload until req_ready. The arbiter does not check this.
- Arithmetic: modulo 2^32 sum, {rsp_cout,rsp_sum} = a+b+cin exactly. No signed overflow flag.
- Reset asserted mid-stall drops the pending result: no response and no req_ready until rst_n rises. Arbitration restarts at requester 0.
- X on req_a or req_b of non-winning requesters must not propagate to any output.

Test Plan:
- Single request: req 2 with a=0x0000_0005, b=0x0000_0003, cin=1, rsp_ready=1 -> req_ready=4'b0100 that cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_sum=0x0000_0009, rsp_cout=0.
- Carry-out/wrap: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> rsp_sum=0x0000_0000, rsp_cout=1. Also a=b=0xFFFF_FFFF, cin=1 -> rsp_sum=0xFFFF_FFFF, rsp_cout=1.
- Round-robin: all 4 req_valid held high with distinct operands after reset, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles. rsp_valid stays 1 every cycle (full throughput) and each rsp_sum matches its requester.
- Backpressure: rsp_ready=0 for 3 cycles after the first result -> rsp fields stable, req_ready=0. When rsp_ready rises, the next winner is accepted in that same cycle: simultaneous drain and fill, no bubble.
- Priority retention: req 1 accepted, then 2 idle cycles, then req 0 and req 3 both valid -> req 3 granted first (search starts at 2).
- Reset mid-stall: rsp_valid=1, rsp_ready=0, pulse rst_n low asynchronously between edges -> rsp_valid, rsp_sum, rsp_cout and rsp_id go to 0 immediately. After release, req 0 and req 2 both valid -> req 0 granted.
